// File: rtl/chrom_pkg.sv
// Shared parameter set for the chromosome loader and the evaluator: geometry,
// derived frame widths, FSM encodings and the frame-to-field unpack helper.
package chrom_pkg;

  localparam int ROW     = 3;
  localparam int COL     = 1;
  localparam int IN      = 3;
  localparam int OUT     = 1;
  localparam int SEL_W   = (ROW * COL > 1) ? $clog2(ROW * COL) : 1;
  localparam int CHROM_W = ROW * COL * 16 + OUT * SEL_W;
  localparam int CNT_W   = $clog2(CHROM_W);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SHIFT  = 2'd1;
  localparam state_t ST_PAR    = 2'd2;
  localparam state_t ST_COMMIT = 2'd3;

  typedef logic [ROW-1:0][COL-1:0][15:0] le_tt_t;
  typedef logic [OUT-1:0][SEL_W-1:0]     sel_t;

  // Field order mirrors the serial frame: truth tables in the MSBs, selectors last.
  typedef struct packed {
    le_tt_t le;
    sel_t   sel;
  } chrom_t;

  function automatic chrom_t unpack_frame(input logic [CHROM_W-1:0] frame);
    return chrom_t'(frame);
  endfunction

endpackage

// File: rtl/chrom_shift_reg.sv
// Shadow register for the incoming chromosome: MSB-first serial shift with
// synchronous clear; tracks running even parity when CHROM_PARITY_EN is defined.
module chrom_shift_reg
  import chrom_pkg::*;
#(
  parameter int W = CHROM_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         shift_i,
  input  logic         bit_i,
`ifdef CHROM_PARITY_EN
  output logic         parity_o,
`endif
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
    end else if (shift_i) begin
      data_q <= {data_q[W-2:0], bit_i};
    end
  end

  assign data_o = data_q;

`ifdef CHROM_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (clr_i) begin
      parity_q <= 1'b0;
    end else if (shift_i) begin
      parity_q <= parity_q ^ bit_i;
    end
  end

  assign parity_o = parity_q;
`endif

endmodule

// File: rtl/chrom_serial_loader.sv
// Serial-to-parallel, double-buffered chromosome loader for the circuit evaluator.
// Optional trailing even-parity bit with frame rejection: define CHROM_PARITY_EN.
module chrom_serial_loader
  import chrom_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_start,
  input  logic                          ser_valid,
  input  logic                          ser_data,
  output logic                          ser_ready,
  output logic [ROW-1:0][COL-1:0][15:0] saidas_LE,
  output logic [OUT-1:0][SEL_W-1:0]     out_chrom,
  output logic                          chrom_valid,
  output logic                          load_done,
  output logic                          load_err
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CHROM_W-1:0] active_q, active_d;
  logic               valid_q, valid_d;
  logic [CHROM_W-1:0] shadow;
  logic [CHROM_W-1:0] active_frame;
  chrom_t             active_f;
  logic               shift_en, clr, accept, last_bit;

`ifdef CHROM_PARITY_EN
  logic parity;
  logic err_q, err_d;
`endif

  chrom_shift_reg #(.W(CHROM_W)) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .shift_i (shift_en),
    .bit_i   (ser_data),
`ifdef CHROM_PARITY_EN
    .parity_o(parity),
`endif
    .data_o  (shadow)
  );

  // A start request takes priority over a bit offered in the same cycle.
  assign ser_ready = ((state_q == ST_SHIFT) || (state_q == ST_PAR)) && !load_start;
  assign accept    = ser_ready && ser_valid;
  assign last_bit  = (cnt_q == CNT_W'(CHROM_W - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    valid_d  = valid_q;
    shift_en = 1'b0;
    clr      = 1'b0;
`ifdef CHROM_PARITY_EN
    err_d    = 1'b0;
`endif
    // Completes the copy even when a new start arrives in the commit cycle.
    if (state_q == ST_COMMIT) begin
      active_d = shadow;
      valid_d  = 1'b1;
    end
    if (load_start) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      clr     = 1'b1;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (accept) begin
            shift_en = 1'b1;
            cnt_d    = last_bit ? '0 : cnt_q + 1'b1;
            if (last_bit) begin
`ifdef CHROM_PARITY_EN
              state_d = ST_PAR;
`else
              state_d = ST_COMMIT;
`endif
            end
          end
        end
        ST_PAR: begin
`ifdef CHROM_PARITY_EN
          if (accept) begin
            if (ser_data == parity) begin
              state_d = ST_COMMIT;
            end else begin
              state_d = ST_IDLE;
              err_d   = 1'b1;
            end
          end
`else
          state_d = ST_IDLE;
`endif
        end
        ST_COMMIT: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      active_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      valid_q  <= valid_d;
    end
  end

`ifdef CHROM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

  // During COMMIT the shadow is shown directly, so the new config appears on the
  // edge that leaves SHIFT/PAR; active_q holds the identical value from then on.
  assign active_frame = (state_q == ST_COMMIT) ? shadow : active_q;
  assign active_f     = unpack_frame(active_frame);
  assign saidas_LE    = active_f.le;
  assign out_chrom    = active_f.sel;
  assign chrom_valid  = valid_q || (state_q == ST_COMMIT);
  assign load_done    = (state_q == ST_COMMIT);

endmodule

// File: tb/tb_chrom_serial_loader.sv
// Self-checking bench for chrom_serial_loader: vector table of frames plus
// abort, stall, reset and parity sequences; commits checked via a scoreboard.
module tb_chrom_serial_loader;
  import chrom_pkg::*;

`ifdef CHROM_PARITY_EN
  localparam int FRAME_LEN = CHROM_W + 1;
`else
  localparam int FRAME_LEN = CHROM_W;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_start = 1'b0;
  logic ser_valid = 1'b0;
  logic ser_data = 1'b0;
  logic ser_ready;
  logic [ROW-1:0][COL-1:0][15:0] saidas_LE;
  logic [OUT-1:0][SEL_W-1:0] out_chrom;
  logic chrom_valid, load_done, load_err;

  chrom_serial_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .ser_valid  (ser_valid),
    .ser_data   (ser_data),
    .ser_ready  (ser_ready),
    .saidas_LE  (saidas_LE),
    .out_chrom  (out_chrom),
    .chrom_valid(chrom_valid),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] t2;
    logic [15:0] t1;
    logic [15:0] t0;
    logic [1:0]  sel;
  } exp_t;

  typedef struct {
    logic [15:0] t2;
    logic [15:0] t1;
    logic [15:0] t0;
    logic [1:0]  sel;
    bit          rnd;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   err_expect = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Commit scoreboard: every load_done must match the oldest pending frame.
  always @(negedge clk) begin
    if (rst_n && load_done) begin
      if (sb_q.size() == 0) begin
        chk("load_done_spurious", {63'd0, load_done}, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("commit_le2", saidas_LE[2][0], mon_e.t2);
        chk("commit_le1", saidas_LE[1][0], mon_e.t1);
        chk("commit_le0", saidas_LE[0][0], mon_e.t0);
        chk("commit_sel", out_chrom[0], mon_e.sel);
        chk("commit_valid", chrom_valid, 1);
        $display("commit: LE2=%h LE1=%h LE0=%h sel=%0d", saidas_LE[2][0], saidas_LE[1][0],
                 saidas_LE[0][0], out_chrom[0]);
      end
    end
    if (rst_n && load_err) begin
      if (err_expect > 0) begin
        err_expect--;
        $display("reject: load_err pulse");
      end else begin
        chk("load_err_spurious", {63'd0, load_err}, 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    load_start = 1'b1;
    ser_valid  = 1'b0;
    tick();
    load_start = 1'b0;
  endtask

  // Sends vec[CHROM_W], vec[CHROM_W-1], ... one accepted bit at a time.
  task automatic send_bits(input logic [CHROM_W:0] vec, input int nbits, input bit rnd,
                           output int accepts);
    int  guard;
    bit  done;
    accepts = 0;
    for (int i = 0; i < nbits; i++) begin
      ser_data = vec[CHROM_W-i];
      done  = 1'b0;
      guard = 0;
      while (!done) begin
        ser_valid = rnd ? ($urandom_range(2) == 0) : 1'b1;
        @(negedge clk);
        if (ser_valid && ser_ready) begin
          done = 1'b1;
          accepts++;
        end
        tick();
        guard++;
        if (!done && guard > 200) begin
          ser_valid = 1'b0;
          fail_now("accept_timeout");
          return;
        end
      end
    end
    ser_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] t2, input logic [15:0] t1, input logic [15:0] t0,
                            input logic [1:0] sel, input bit rnd, input bit bad_par);
    logic [CHROM_W-1:0] f;
    logic [CHROM_W:0]   v;
    int                 acc;
    exp_t               e;
    f = {t2, t1, t0, sel};
    v = {f, (^f) ^ bad_par};
    e.t2 = t2; e.t1 = t1; e.t0 = t0; e.sel = sel;
    if (bad_par) err_expect++;
    else sb_q.push_back(e);
    start();
    send_bits(v, FRAME_LEN, rnd, acc);
    chk("accept_count", acc, FRAME_LEN);
    if (bad_par) begin
      chk("err_pulse", load_err, 1);
      chk("err_no_done", load_done, 0);
    end else begin
      chk("done_after_last", load_done, 1);
    end
    tick();
    chk("done_one_cycle", load_done, 0);
    chk("err_one_cycle", load_err, 0);
  endtask

  task automatic chk_active(input string name, input logic [15:0] t2, input logic [15:0] t1,
                            input logic [15:0] t0, input logic [1:0] sel, input logic vld);
    chk({name, "_le"}, saidas_LE, {t2, t1, t0});
    chk({name, "_sel"}, out_chrom, sel);
    chk({name, "_valid"}, chrom_valid, vld);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    logic [CHROM_W:0] part;
    int acc;

    vecs[0] = '{16'hAAAA, 16'h5555, 16'hFFFF, 2'b10, 1'b0};
    vecs[1] = '{16'hAAAA, 16'h5555, 16'hFFFF, 2'b10, 1'b1};
    vecs[2] = '{16'h8001, 16'h0F0F, 16'h7E00, 2'b11, 1'b0};
    vecs[3] = '{16'h0000, 16'hFFFF, 16'h0001, 2'b00, 1'b1};
    vecs[4] = '{16'hAAAA, 16'h5555, 16'hFFFF, 2'b10, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_active("reset", 16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
    chk("reset_ready", ser_ready, 0);
    chk("reset_done", load_done, 0);
    rst_n = 1'b1;
    tick();
    chk_active("post_reset", 16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
    chk("idle_ready", ser_ready, 0);

    // Table: full frames, plain and with random valid gaps
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].t2, vecs[i].t1, vecs[i].t0, vecs[i].sel, vecs[i].rnd, 1'b0);
      chk_active("table_hold", vecs[i].t2, vecs[i].t1, vecs[i].t0, vecs[i].sel, 1'b1);
    end

    // ser_valid in IDLE is ignored
    ser_valid = 1'b1;
    ser_data  = 1'b1;
    repeat (3) tick();
    chk("idle_ignore_ready", ser_ready, 0);
    ser_valid = 1'b0;
    chk_active("idle_ignore", 16'hAAAA, 16'h5555, 16'hFFFF, 2'b10, 1'b1);

    // Partial all-zero frame stalled at bit 30: active config untouched
    start();
    part = '0;
    send_bits(part, 30, 1'b0, acc);
    chk("partial_accepts", acc, 30);
    repeat (10) tick();
    chk("stall_ready", ser_ready, 1);
    chk_active("stall_hold", 16'hAAAA, 16'h5555, 16'hFFFF, 2'b10, 1'b1);

    // Restart at bit 20 of another frame; only the following full frame commits
    start();
    part = {16'hDEAD, 16'hBEEF, 16'hCAFE, 2'b01, 1'b0};
    send_bits(part, 20, 1'b0, acc);
    chk_active("abort_hold", 16'hAAAA, 16'h5555, 16'hFFFF, 2'b10, 1'b1);
    send_frame(16'h1234, 16'h0000, 16'hFFFF, 2'b01, 1'b0, 1'b0);
    chk_active("after_abort", 16'h1234, 16'h0000, 16'hFFFF, 2'b01, 1'b1);

    // Async reset at bit 40
    start();
    part = {16'h0F0F, 16'hF0F0, 16'h3C3C, 2'b11, 1'b0};
    send_bits(part, 40, 1'b0, acc);
    rst_n = 1'b0;
    #1;
    chk_active("async_reset", 16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
    chk("async_reset_ready", ser_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(16'h0F0F, 16'hF0F0, 16'h3C3C, 2'b11, 1'b0, 1'b0);
    chk_active("post_async", 16'h0F0F, 16'hF0F0, 16'h3C3C, 2'b11, 1'b1);

`ifdef CHROM_PARITY_EN
    send_frame(16'h1357, 16'h2468, 16'h9ABC, 2'b10, 1'b0, 1'b0);
    chk_active("par_ok", 16'h1357, 16'h2468, 16'h9ABC, 2'b10, 1'b1);
    send_frame(16'hFFFF, 16'h0000, 16'h0001, 2'b01, 1'b0, 1'b1);
    chk_active("par_bad_hold", 16'h1357, 16'h2468, 16'h9ABC, 2'b10, 1'b1);
`endif

    repeat (3) tick();
    chk("scoreboard_empty", sb_q.size(), 0);
    chk("err_expect_empty", err_expect, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
